// File: rtl/smol_fetch_unit.sv
// Instruction fetch unit: drives a 1-cycle-latency instruction ROM and buffers
// returned words in a 2-entry FIFO so decode back-pressure never drops work.
module smol_fetch_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH+1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH+1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH+1:0] out_pc
);
    localparam int PW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] RESET_PC_W = PW'(RESET_PC);
    localparam logic [PW-1:0] PC_STEP    = PW'(4);

    logic [PW-1:0]         r_fetch_pc;
    logic [PW-1:0]         r_inflight_pc;
    logic                  r_inflight;
    logic [PW-1:0]         r_fifo_pc    [2];
    logic [DATA_WIDTH-1:0] r_fifo_instr [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [2:0]            w_occupancy;
    logic [PW-1:0]         w_redirect_target;
    logic                  w_unused_pc_lsb;

    // Occupancy counts the in-flight word as already buffered, net of this
    // cycle's pop, so a returning word always finds a free FIFO slot.
    always_comb begin
        w_pop             = (r_count != 2'd0) & out_ready;
        w_push            = r_inflight & ~redirect_valid;
        w_occupancy       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue           = ~redirect_valid & (w_occupancy < 3'd2);
        w_redirect_target = {redirect_pc[PW-1:2], 2'b00};
    end

    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC_W;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
                r_fifo_instr[r_wr_ptr] <= imem_data;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_comb begin
        imem_addr = r_fetch_pc;
        out_valid = (r_count != 2'd0);
        out_instr = r_fifo_instr[r_rd_ptr];
        out_pc    = r_fifo_pc[r_rd_ptr];
    end

endmodule

// File: tb/tb_smol_fetch_unit.sv
// Bench for smol_fetch_unit: directed scenarios plus a randomized stall/redirect
// run checked against a next-expected-PC reference model.
module tb_smol_fetch_unit;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int PW = AW + 2;
    localparam logic [PW-1:0] RST_PC = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          redirect_valid = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [PW-1:0] out_pc;

    logic [DW-1:0] mem [0:1023];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr[PW-1:2]];

    smol_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    // Applies one reset edge; returns at the negedge where rst_n is released.
    task automatic apply_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== '0) begin errors++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
    endtask

    task automatic test_startup();
        logic [PW-1:0] epc;
        apply_reset();
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL startup_early got=%b exp=0", out_valid); end
        @(negedge clk);
        epc = RST_PC;
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL startup_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_pc !== epc) begin errors++; $display("FAIL startup_pc k=%0d got=%h exp=%h", k, out_pc, epc); end
            checks++; if (out_instr !== 32'h1000_0000 + DW'(k)) begin errors++; $display("FAIL startup_instr k=%0d got=%h exp=%h", k, out_instr, 32'h1000_0000 + DW'(k)); end
            epc += PW'(4);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 12'h000 || out_instr !== mem[0]) begin
                errors++; $display("FAIL bp_hold k=%0d got=%b/%h/%h exp=1/000/%h", k, out_valid, out_pc, out_instr, mem[0]);
            end
            if (k > 0) begin
                checks++; if (dut.r_count !== 2'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", dut.r_count); end
                checks++; if (imem_addr !== 12'h008) begin errors++; $display("FAIL bp_fetch_stop got=%h exp=008", imem_addr); end
            end
            if (k < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_pc !== PW'(4 * (k + 1))) begin
                errors++; $display("FAIL bp_release k=%0d got=%b/%h exp=1/%h", k, out_valid, out_pc, PW'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (out_pc !== 12'h008) begin errors++; $display("FAIL rd_setup got=%h exp=008", out_pc); end
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (dut.r_count !== 2'd2) begin errors++; $display("FAIL rd_full got=%0d exp=2", dut.r_count); end
        redirect_valid = 1'b1; redirect_pc = 12'h103; out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_flush got=%b exp=0", out_valid); end
        checks++; if (imem_addr !== 12'h100) begin errors++; $display("FAIL rd_addr got=%h exp=100", imem_addr); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_gap got=%b exp=0", out_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_pc !== PW'(12'h100 + 4 * k) || out_instr !== mem[64 + k]) begin
                errors++; $display("FAIL rd_newpath k=%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, out_pc, out_instr, PW'(12'h100 + 4 * k), mem[64 + k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] exp_pcs [3];
        exp_pcs[0] = 12'hFFC; exp_pcs[1] = 12'h000; exp_pcs[2] = 12'h004;
        redirect_valid = 1'b1; redirect_pc = 12'hFFC; out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush got=%b exp=0", out_valid); end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pcs[k] || out_instr !== mem[exp_pcs[k][PW-1:2]]) begin
                errors++; $display("FAIL wrap k=%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, out_pc, out_instr, exp_pcs[k], mem[exp_pcs[k][PW-1:2]]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dut.r_count !== 2'd2) begin errors++; $display("FAIL mid_full got=%0d exp=2", dut.r_count); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL mid_addr got=%h exp=%h", imem_addr, RST_PC); end
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_early got=%b exp=0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC || out_instr !== mem[0]) begin
            errors++; $display("FAIL mid_restart got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_instr, RST_PC, mem[0]);
        end
    endtask

    // Model: the next delivered pc is the last accepted pc + 4, or the aligned
    // redirect target; a flush shows 2 empty cycles, then output never starves.
    task automatic test_stress();
        logic [PW-1:0] exp_pc;
        logic [PW-1:0] prev_pc;
        logic [DW-1:0] prev_instr;
        logic          prev_hold;
        int            age;
        for (int k = 0; k < 1024; k++) mem[k] = $urandom;
        apply_reset();
        out_ready = 1'b1;
        exp_pc = RST_PC; age = 1; prev_hold = 1'b0; prev_pc = '0; prev_instr = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (age < 100) age++;
            checks++; if (dut.r_count > 2'd2) begin errors++; $display("FAIL st_count c=%0d got=%0d exp<=2", c, dut.r_count); end
            checks++; if (out_valid !== (age >= 3)) begin errors++; $display("FAIL st_valid c=%0d got=%b exp=%b", c, out_valid, age >= 3); end
            if (out_valid) begin
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL st_pc c=%0d got=%h exp=%h", c, out_pc, exp_pc); end
                checks++; if (out_instr !== mem[out_pc[PW-1:2]]) begin errors++; $display("FAIL st_instr c=%0d got=%h exp=%h", c, out_instr, mem[out_pc[PW-1:2]]); end
            end
            if (prev_hold) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
                    errors++; $display("FAIL st_stall c=%0d got=%b/%h/%h exp=1/%h/%h", c, out_valid, out_pc, out_instr, prev_pc, prev_instr);
                end
            end
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = PW'($urandom);
            prev_hold  = out_valid & ~out_ready & ~redirect_valid;
            prev_pc    = out_pc;
            prev_instr = out_instr;
            if (out_valid && out_ready) exp_pc = exp_pc + PW'(4);
            if (redirect_valid) begin
                exp_pc = {redirect_pc[PW-1:2], 2'b00};
                age = 0;
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + DW'(k);
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midstream();
        test_stress();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
